// File: rtl/pipeline_ctrl_if.sv
// Bundle of pipeline hazard inputs and control/status outputs for pipeline_ctrl.
// Every signal is level-sensitive and sampled each cycle; there is no valid/ready handshake.
interface pipeline_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       idex_rd;
  logic             idex_memread;
  logic [4:0]       ifid_rs1;
  logic [4:0]       ifid_rs2;
  logic             ex_branch_taken;
  logic             dmem_req;
  logic             dmem_ready;

  logic             pc_write;
  logic             ifid_write;
  logic             ifid_flush;
  logic             idex_write;
  logic             idex_flush;
  logic             exmem_write;
  logic             memwb_flush;
  logic             fault;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic [1:0]       state;

  modport master (
    output idex_rd, idex_memread, ifid_rs1, ifid_rs2,
           ex_branch_taken, dmem_req, dmem_ready,
    input  pc_write, ifid_write, ifid_flush, idex_write, idex_flush,
           exmem_write, memwb_flush, fault, stall_cnt, flush_cnt, state
  );

  modport slave (
    input  idex_rd, idex_memread, ifid_rs1, ifid_rs2,
           ex_branch_taken, dmem_req, dmem_ready,
    output pc_write, ifid_write, ifid_flush, idex_write, idex_flush,
           exmem_write, memwb_flush, fault, stall_cnt, flush_cnt, state
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Hazard controller for a 5-stage pipeline: memory stalls, branch flushes, load-use
// bubbles, a memory-timeout fault state and saturating stall/flush counters.
module pipeline_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  pipeline_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FAULT    = 2'd2
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t           state_q;
  logic [7:0]       wait_cnt;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  logic mem_stall;
  logic load_use;
  logic branch_flush;
  logic pc_write;
  logic ifid_write;
  logic ifid_flush;
  logic idex_write;
  logic idex_flush;
  logic exmem_write;
  logic memwb_flush;

  assign mem_stall = bus.dmem_req & ~bus.dmem_ready;
  assign load_use  = bus.idex_memread & (bus.idex_rd != 5'd0) &
                     ((bus.idex_rd == bus.ifid_rs1) | (bus.idex_rd == bus.ifid_rs2));

  // Reset forcing and FAULT override every hazard; hazards then resolve by priority.
  always_comb begin
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    ifid_flush   = 1'b0;
    idex_write   = 1'b1;
    idex_flush   = 1'b0;
    exmem_write  = 1'b1;
    memwb_flush  = 1'b0;
    branch_flush = 1'b0;
    if (!rst_n || state_q == FAULT) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_write  = 1'b0;
      idex_flush  = 1'b1;
      exmem_write = 1'b0;
      memwb_flush = 1'b1;
    end else if (mem_stall) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_write = 1'b0;
      memwb_flush = 1'b1;
    end else if (bus.ex_branch_taken) begin
      ifid_flush   = 1'b1;
      idex_flush   = 1'b1;
      branch_flush = 1'b1;
    end else if (load_use) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_flush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= RUN;
      wait_cnt  <= 8'd0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (state_q != FAULT) begin
      if (mem_stall) begin
        wait_cnt <= wait_cnt + 8'd1;
        state_q  <= (wait_cnt == WAIT_LAST) ? FAULT : MEM_WAIT;
      end else begin
        wait_cnt <= 8'd0;
        state_q  <= RUN;
      end
      if (!pc_write && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      if (branch_flush && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
    end
  end

  assign bus.pc_write    = pc_write;
  assign bus.ifid_write  = ifid_write;
  assign bus.ifid_flush  = ifid_flush;
  assign bus.idex_write  = idex_write;
  assign bus.idex_flush  = idex_flush;
  assign bus.exmem_write = exmem_write;
  assign bus.memwb_flush = memwb_flush;
  assign bus.fault       = rst_n & (state_q == FAULT);
  assign bus.stall_cnt   = stall_cnt;
  assign bus.flush_cnt   = flush_cnt;
  assign bus.state       = state_q;

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 16: consecutive data-memory stall cycles before fault; legal range 2..255.
REQ-002 Parameter CNT_W, default 16: width of the performance counters.
REQ-003 clk  in  1  single clock; every register updates on the rising edge.
REQ-004 rst_n  in  1  synchronous, active-low reset; sampled only on the rising edge of clk.
REQ-005 idex_rd  in  5  destination register of the instruction in ID/EX.
REQ-006 idex_memread  in  1  instruction in ID/EX is a load.
REQ-007 ifid_rs1, ifid_rs2  in  5 each  source registers of the instruction in IF/ID.
REQ-008 ex_branch_taken  in  1  branch or jump resolved taken in EX this cycle.
REQ-009 dmem_req  in  1  MEM stage holds a valid data-memory access.
REQ-010 dmem_ready  in  1  data memory completes the access this cycle.
REQ-011 pc_write  out  1  PC load enable.
REQ-012 ifid_write  out  1  IF/ID load enable.
REQ-013 ifid_flush  out  1  IF/ID cleared to NOP.
REQ-014 idex_write  out  1  ID/EX load enable.
REQ-015 idex_flush  out  1  ID/EX control fields zeroed (bubble).
REQ-016 exmem_write  out  1  EX/MEM load enable.
REQ-017 memwb_flush  out  1  MEM/WB control fields zeroed (bubble).
REQ-018 fault  out  1  sticky memory-timeout indication.
REQ-019 stall_cnt, flush_cnt  out  CNT_W each  saturating performance counters.
REQ-020 state  out  2  FSM state: RUN=0, MEM_WAIT=1, FAULT=2.

Function
REQ-021 mem_stall = dmem_req & ~dmem_ready; load_use = idex_memread & (idex_rd != 0) & ((idex_rd == ifid_rs1) | (idex_rd == ifid_rs2)).
REQ-022 All control outputs are combinational from state and the current inputs, with zero-cycle latency.
REQ-023 Default in RUN and MEM_WAIT: all write enables 1, all flushes 0.
REQ-024 Priority 1, mem_stall: pc_write, ifid_write, idex_write and exmem_write are 0; memwb_flush is 1; branch and load-use are ignored.
REQ-025 Priority 2, ex_branch_taken with no mem_stall: pc_write is 1, ifid_flush is 1 and idex_flush is 1; load_use is ignored.
REQ-026 Priority 3, load_use only: pc_write and ifid_write are 0; idex_flush is 1; idex_write and exmem_write are 1.
REQ-027 A register-0 destination never causes a load-use stall.
REQ-028 FSM RUN -> MEM_WAIT on mem_stall; MEM_WAIT -> RUN on ~mem_stall; MEM_WAIT holds otherwise.
REQ-029 wait_cnt (8 bits, internal) increments on every cycle with mem_stall and clears on every cycle without it.
REQ-030 FSM RUN/MEM_WAIT -> FAULT on the edge where mem_stall is true and wait_cnt == TIMEOUT-1, i.e. after TIMEOUT consecutive stall cycles.
REQ-031 FAULT is absorbing until reset: all write enables 0, ifid_flush, idex_flush and memwb_flush 1, fault 1.
REQ-032 stall_cnt increments by 1 on each non-FAULT cycle with pc_write == 0 and holds at 2^CNT_W-1.
REQ-033 flush_cnt increments by 1 on each non-FAULT cycle where REQ-025 applies and holds at 2^CNT_W-1.
REQ-034 Counters do not change in FAULT.

Reset
REQ-035 rst_n low at an edge: state becomes RUN; wait_cnt, stall_cnt, flush_cnt and fault become 0.
REQ-036 While rst_n is low, outputs are forced: all write enables 0, all flushes 1, fault 0.
REQ-037 Reset asserted during MEM_WAIT or FAULT discards the stall; the first cycle after rst_n rises behaves as RUN.

Verification
REQ-038 Load-use: idex_memread=1, idex_rd=5, ifid_rs2=5, all other inputs 0 -> pc_write=0, ifid_write=0, idex_flush=1; stall_cnt 0 -> 1 after the edge.
REQ-039 idex_rd=0, idex_memread=1, ifid_rs1=0 -> no stall; all enables 1.
REQ-040 ex_branch_taken=1 with load_use true -> pc_write=1, ifid_flush=1, idex_flush=1; flush_cnt += 1; stall_cnt unchanged.
REQ-041 dmem_req=1, dmem_ready=0 for 3 cycles, then ready=1, with ex_branch_taken=1 throughout -> 3 cycles frozen with memwb_flush=1; state RUN, MEM_WAIT, MEM_WAIT, then RUN; the branch flush applies only on the ready cycle.
REQ-042 TIMEOUT=4, dmem_ready held 0 -> state=2 and fault=1 after the 4th stall edge; a later dmem_ready=1 does not change state; rst_n=0 for one edge -> state=0, fault=0, counters 0.
REQ-043 CNT_W=4, 20 consecutive load-use cycles -> stall_cnt saturates at 15.
